// File: rtl/sr_latch_checker.sv
// Clocked reference-model checker for a cross-coupled NOR SR latch.
// Tracks the expected latch state, flags mismatches once per stable window.
module sr_latch_checker #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             q_exp,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] forb_cnt
);

  typedef enum logic [1:0] {
    UNK   = 2'b00,
    VALID = 2'b01,
    FORB  = 2'b10
  } st_e;

  localparam logic [3:0]       SET_C = 4'(SETTLE);
  localparam logic [CNT_W-1:0] SAT   = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  st_e              st_q;
  logic             qexp_q;
  logic             err_q;
  logic [CNT_W-1:0] errc_q;
  logic [CNT_W-1:0] forbc_q;
  logic [3:0]       cnt_q;
  logic             win_q;
  logic             s_q;
  logic             r_q;

  logic chg;
  logic active;
  logic mism;
  logic fire;

  // A change in the current sample means the window restarts this edge
  always_comb begin
    chg    = (s != s_q) || (r != r_q);
    active = !chg && (cnt_q == SET_C);
    mism   = 1'b0;
    case (st_q)
      VALID:   mism = (q != qexp_q) || (qbar != ~qexp_q);
      FORB:    mism = q || qbar;
      default: mism = (qbar == q);
    endcase
    fire = active && mism && !win_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= UNK;
      qexp_q  <= 1'b0;
      err_q   <= 1'b0;
      errc_q  <= '0;
      forbc_q <= '0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      s_q   <= s;
      r_q   <= r;
      err_q <= fire;
      if (fire && errc_q != SAT)
        errc_q <= errc_q + ONE;
      if (chg) begin
        cnt_q <= '0;
        win_q <= 1'b0;
      end else begin
        if (cnt_q != SET_C)
          cnt_q <= cnt_q + 4'd1;
        if (fire)
          win_q <= 1'b1;
      end
      unique case (1'b1)
        (s && !r): begin
          st_q   <= VALID;
          qexp_q <= 1'b1;
        end
        (!s && r): begin
          st_q   <= VALID;
          qexp_q <= 1'b0;
        end
        (s && r): begin
          if (st_q != FORB) begin
            st_q <= FORB;
            if (forbc_q != SAT)
              forbc_q <= forbc_q + ONE;
          end
        end
        default: begin
          // Releasing both inputs from FORB races; outcome unknown
          if (st_q == FORB) begin
            st_q   <= UNK;
            qexp_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign q_exp    = qexp_q;
  assign state    = st_q;
  assign err      = err_q;
  assign err_cnt  = errc_q;
  assign forb_cnt = forbc_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Scoreboard bench for sr_latch_checker.
// A behavioural model queues expectations as stimulus is applied.
module tb_sr_latch_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam int SATV   = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s = 1'b0;
  logic             r = 1'b0;
  logic             q = 1'b0;
  logic             qbar = 1'b1;
  logic             q_exp;
  logic [1:0]       state;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] forb_cnt;

  sr_latch_checker #(
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s       (s),
    .r       (r),
    .q       (q),
    .qbar    (qbar),
    .q_exp   (q_exp),
    .state   (state),
    .err     (err),
    .err_cnt (err_cnt),
    .forb_cnt(forb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       qe;
    logic       er;
    logic [7:0] ec;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  int m_st = 0;
  int m_qe = 0;
  int m_cnt = 0;
  int m_win = 0;
  int m_ec = 0;
  int m_fc = 0;
  int m_err = 0;
  logic m_sd = 1'b0;
  logic m_rd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rs, input logic si, input logic ri,
                       input logic qi, input logic qbi);
    logic chg;
    logic bad;
    if (rs) begin
      m_st = 0; m_qe = 0; m_cnt = 0; m_win = 0;
      m_ec = 0; m_fc = 0; m_err = 0;
      m_sd = 1'b0; m_rd = 1'b0;
      return;
    end
    chg = (si !== m_sd) || (ri !== m_rd);
    if (m_st == 1)
      bad = (qi !== 1'(m_qe)) || (qbi !== !1'(m_qe));
    else if (m_st == 2)
      bad = (qi !== 1'b0) || (qbi !== 1'b0);
    else
      bad = (qbi !== !qi);
    m_err = (!chg && m_cnt == SETTLE && bad && m_win == 0) ? 1 : 0;
    if (m_err == 1 && m_ec < SATV) m_ec++;
    if (chg) begin
      m_cnt = 0;
      m_win = 0;
    end else begin
      if (m_cnt < SETTLE) m_cnt++;
      if (m_err == 1) m_win = 1;
    end
    if (si && !ri) begin
      m_st = 1; m_qe = 1;
    end else if (!si && ri) begin
      m_st = 1; m_qe = 0;
    end else if (si && ri) begin
      if (m_st != 2) begin
        m_st = 2;
        if (m_fc < SATV) m_fc++;
      end
    end else if (m_st == 2) begin
      m_st = 0; m_qe = 0;
    end
    m_sd = si;
    m_rd = ri;
  endtask

  task automatic step(input logic rs, input logic si, input logic ri,
                      input logic qi, input logic qbi);
    exp_t e;
    @(negedge clk);
    rst = rs; s = si; r = ri; q = qi; qbar = qbi;
    model(rs, si, ri, qi, qbi);
    e.st = 2'(m_st);
    e.qe = 1'(m_qe);
    e.er = 1'(m_err);
    e.ec = 8'(m_ec);
    e.fc = 8'(m_fc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("q_exp", 32'(q_exp), 32'(e.qe));
      chk("err", 32'(err), 32'(e.er));
      chk("err_cnt", 32'(err_cnt), 32'(e.ec));
      chk("forb_cnt", 32'(forb_cnt), 32'(e.fc));
    end
  endtask

  int npulse;
  int pidx;

  initial begin
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_errcnt", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0);
    chk("set_state", 32'(state), 32'd1);
    chk("set_qexp", 32'(q_exp), 32'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    chk("hold_qexp", 32'(q_exp), 32'd1);

    npulse = 0;
    pidx = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1, 0);
      if (err) begin
        npulse++;
        pidx = i;
      end
    end
    chk("one_pulse", 32'(npulse), 32'd1);
    chk("pulse_idx", 32'(pidx), 32'(SETTLE + 1));
    chk("errcnt_1", 32'(err_cnt), 32'd1);

    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      if (k == 0) chk("forb_state", 32'(state), 32'd2);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
      if (k == 0) chk("forb_cnt_1", 32'(forb_cnt), 32'd1);
    end
    chk("unk_state", 32'(state), 32'd0);
    chk("forb_cnt_3", 32'(forb_cnt), 32'd3);

    for (int w = 0; w < 300; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w % 2 == 0) step(0, 1, 0, 0, 1);
        else step(0, 0, 1, 1, 0);
      end
    end
    chk("errcnt_sat", 32'(err_cnt), 32'(SATV));

    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) step(0, 1, 0, 0, 1);
      else step(0, 0, 1, 1, 0);
      if (err) npulse++;
    end
    chk("toggle_noerr", 32'(npulse), 32'd0);

    for (int i = 0; i < 300; i++) begin
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 1);
    end
    chk("forbcnt_sat", 32'(forb_cnt), 32'(SATV));

    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);
    chk("post_rst_err", 32'(err_cnt), 32'd1);

    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("rel_forb", 32'(state), 32'd2);
    chk("rel_fcnt", 32'(forb_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
